// File: rtl/instr_enc_pkg.sv
// Shared constants for the imem loader.
// Opcodes, descriptor kinds, FSM states.
package instr_enc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] K_RTYPE = 3'd0;
  localparam logic [2:0] K_ADDI  = 3'd1;
  localparam logic [2:0] K_ANDI  = 3'd2;
  localparam logic [2:0] K_LW    = 3'd3;
  localparam logic [2:0] K_SW    = 3'd4;
  localparam logic [2:0] K_BEQ   = 3'd5;
  localparam logic [2:0] K_J     = 3'd6;
  localparam logic [2:0] K_ILL   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO for encoded words.
// Extra pointer bit distinguishes full/empty.
module instr_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp;
  logic [AW:0]  r_rp;
  logic         w_push;
  logic         w_pop;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                   (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rp[AW-1:0]];

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end

  // Read/write pointers; reset flushes the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
    end
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Encodes MIPS descriptors and streams them
// into consecutive imem words from a base address.
module instr_encode_loader
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  input  logic              imem_busy,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_overflow
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_last_seen;
  logic              r_wrapped;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W:0]   r_count;
  logic              r_err_ill;
  logic              r_err_ovf;

  logic [31:0] w_word;
  logic        w_ill;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic [32:0] w_head;

  assign in_ready = (r_state == S_LOAD) & ~w_full
                  & ~r_last_seen;
  assign w_push   = in_valid & in_ready;
  assign w_pop    = (r_state == S_LOAD) & ~w_empty
                  & ~imem_busy;

  assign imem_we      = r_we;
  assign imem_addr    = r_waddr;
  assign imem_wdata   = r_wdata;
  assign busy         = r_busy;
  assign done         = r_done;
  assign count        = r_count;
  assign err_illegal  = r_err_ill;
  assign err_overflow = r_err_ovf;

  // Descriptor to 32-bit MIPS word; kind 7 becomes a NOP.
  always_comb begin
    w_word = '0;
    w_ill  = 1'b0;
    unique case (in_kind)
      K_RTYPE: w_word = {OP_RTYPE, in_rs, in_rt, in_rd,
                         in_shamt, in_funct};
      K_ADDI:  w_word = {OP_ADDI, in_rs, in_rt, in_imm};
      K_ANDI:  w_word = {OP_ANDI, in_rs, in_rt, in_imm};
      K_LW:    w_word = {OP_LW, in_rs, in_rt, in_imm};
      K_SW:    w_word = {OP_SW, in_rs, in_rt, in_imm};
      K_BEQ:   w_word = {OP_BEQ, in_rs, in_rt, in_imm};
      K_J:     w_word = {OP_J, in_target};
      default: w_ill  = 1'b1;
    endcase
  end

  instr_fifo #(
    .W     (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({in_last, w_word}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Session FSM with registered write port and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_last_seen <= 1'b0;
      r_wrapped   <= 1'b0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_err_ill   <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_busy      <= 1'b1;
            r_addr      <= base_addr;
            r_count     <= '0;
            r_err_ill   <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_last_seen <= 1'b0;
            r_wrapped   <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_push) begin
            if (in_last) r_last_seen <= 1'b1;
            if (w_ill)   r_err_ill   <= 1'b1;
          end
          if (w_pop) begin
            if (r_wrapped) begin
              r_err_ovf <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_waddr <= r_addr;
              r_wdata <= w_head[31:0];
              r_count <= r_count + 1'b1;
              if (&r_addr) r_wrapped <= 1'b1;
              else         r_addr    <= r_addr + 1'b1;
            end
            if (w_head[32]) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
